// File: rtl/dyn_mem_pkg.sv
// Shared types and helpers for the dynamic-latency single-port memory.
package dyn_mem_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_READ  = 2'd1;
  localparam logic [1:0] ST_WRITE = 2'd2;

  typedef enum logic [1:0] {
    IDLE       = ST_IDLE,
    READ_BUSY  = ST_READ,
    WRITE_BUSY = ST_WRITE
  } dyn_mem_state_t;

  // Counter must hold max_lat-1; never narrower than one bit.
  function automatic int lat_cnt_w(input int max_lat);
    int w;
    w = $clog2(max_lat);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/dyn_mem_latency_counter.sv
// Down-counter shared by read and write latency; loads from IDLE, stops at zero.
module dyn_mem_latency_counter
  import dyn_mem_pkg::*;
#(
  parameter int MAX_LAT = 2,
  localparam int W = lat_cnt_w(MAX_LAT)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                      count <= '0;
    else if (load)                  count <= load_val;
    else if (dec && count != '0)    count <= count - 1'b1;
  end

  assign zero = (count == '0);

endmodule

// File: rtl/dyn_mem_d1.sv
// Single-port memory answering arbiter requests with per-direction latency
// and one-cycle done pulses; read wins when both enables are high.
module dyn_mem_d1
  import dyn_mem_pkg::*;
#(
  parameter int WIDTH         = 32,
  parameter int SIZE          = 16,
  parameter int IDX_SIZE      = 4,
  parameter int READ_LATENCY  = 2,
  parameter int WRITE_LATENCY = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [IDX_SIZE-1:0] addr,
  input  logic                read_en,
  input  logic                write_en,
  input  logic [WIDTH-1:0]    in,
  output logic [WIDTH-1:0]    out,
  output logic                read_done,
  output logic                write_done,
  output logic                busy
);

  localparam int MAX_LAT = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
  localparam int CW      = lat_cnt_w(MAX_LAT);
  localparam int AW      = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam logic [CW-1:0]     RD_INIT = CW'(READ_LATENCY - 1);
  localparam logic [CW-1:0]     WR_INIT = CW'(WRITE_LATENCY - 1);
  localparam logic [IDX_SIZE:0] SIZE_L  = (IDX_SIZE + 1)'(SIZE);

  dyn_mem_state_t      state;
  logic [IDX_SIZE-1:0] cap_addr;
  logic [WIDTH-1:0]    cap_data;
  logic [WIDTH-1:0]    mem [SIZE];

  logic          cnt_load;
  logic [CW-1:0] cnt_val;
  logic          cnt_zero;
  logic          in_range;
  logic [AW-1:0] mem_idx;

  assign cnt_load = (state == IDLE) && (read_en || write_en);
  assign cnt_val  = read_en ? RD_INIT : WR_INIT;
  assign in_range = ({1'b0, cap_addr} < SIZE_L);
  assign mem_idx  = cap_addr[AW-1:0];

  dyn_mem_latency_counter #(.MAX_LAT(MAX_LAT)) u_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (cnt_val),
    .dec      (state != IDLE),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cap_addr   <= '0;
      cap_data   <= '0;
      out        <= '0;
      read_done  <= 1'b0;
      write_done <= 1'b0;
      busy       <= 1'b0;
    end else begin
      read_done  <= 1'b0;
      write_done <= 1'b0;
      case (state)
        IDLE: begin
          if (read_en) begin
            cap_addr <= addr;
            busy     <= 1'b1;
            state    <= READ_BUSY;
          end else if (write_en) begin
            cap_addr <= addr;
            cap_data <= in;
            busy     <= 1'b1;
            state    <= WRITE_BUSY;
          end
        end
        READ_BUSY: begin
          if (cnt_zero) begin
            out       <= in_range ? mem[mem_idx] : '0;
            read_done <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        WRITE_BUSY: begin
          if (cnt_zero) begin
            write_done <= 1'b1;
            busy       <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Array is deliberately outside the reset domain; reset forces IDLE, so an
  // aborted write never reaches this commit.
  always_ff @(posedge clk) begin
    if (state == WRITE_BUSY && cnt_zero && in_range)
      mem[mem_idx] <= cap_data;
  end

endmodule

// File: tb/tb_dyn_mem_d1.sv
// Directed table-driven bench for dyn_mem_d1 plus async reset/abort sequences.
module tb_dyn_mem_d1;

  logic        clk;
  logic        reset;
  logic [4:0]  addr;
  logic        read_en;
  logic        write_en;
  logic [31:0] din;
  logic [31:0] out;
  logic        read_done;
  logic        write_done;
  logic        busy;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic        re;
    logic        we;
    logic [4:0]  a;
    logic [31:0] d;
    logic        x_rd;
    logic        x_wd;
    logic        x_busy;
    logic [31:0] x_out;
  } vec_t;

  vec_t tbl[$];

  // IDX_SIZE widened so out-of-range addresses (e.g. 20) are representable.
  dyn_mem_d1 #(
    .WIDTH(32), .SIZE(16), .IDX_SIZE(5), .READ_LATENCY(2), .WRITE_LATENCY(1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .addr       (addr),
    .read_en    (read_en),
    .write_en   (write_en),
    .in         (din),
    .out        (out),
    .read_done  (read_done),
    .write_done (write_done),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic row(input logic re, input logic we, input logic [4:0] a,
                     input logic [31:0] d, input logic x_rd, input logic x_wd,
                     input logic x_busy, input logic [31:0] x_out);
    vec_t v;
    v.re = re; v.we = we; v.a = a; v.d = d;
    v.x_rd = x_rd; v.x_wd = x_wd; v.x_busy = x_busy; v.x_out = x_out;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input logic x_rd, input logic x_wd,
                     input logic x_busy, input logic [31:0] x_out);
    n_vec++;
    if (read_done !== x_rd || write_done !== x_wd || busy !== x_busy || out !== x_out) begin
      n_bad++;
      $display("FAIL %s: got rd=%b wd=%b busy=%b out=%h, want rd=%b wd=%b busy=%b out=%h",
               name, read_done, write_done, busy, out, x_rd, x_wd, x_busy, x_out);
    end
  endtask

  task automatic drive(input logic re, input logic we, input logic [4:0] a,
                       input logic [31:0] d);
    read_en = re; write_en = we; addr = a; din = d;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    drive(0, 0, 0, 0);
    reset = 1'b0;
    #1 reset = 1'b1;
    #1 chk("reset_state", 0, 0, 0, 32'h0);
    tick();
    reset = 1'b0;

    // Write addr 3, then read it back.
    row(0, 1, 3, 32'hDEADBEEF, 0, 0, 1, 32'h0);
    row(0, 0, 0, 0,            0, 1, 0, 32'h0);
    row(0, 0, 0, 0,            0, 0, 0, 32'h0);
    row(1, 0, 3, 0,            0, 0, 1, 32'h0);
    row(0, 0, 0, 0,            0, 0, 1, 32'h0);
    row(0, 0, 0, 0,            1, 0, 0, 32'hDEADBEEF);
    row(0, 0, 0, 0,            0, 0, 0, 32'hDEADBEEF);
    // Preload mem[5]=0x22, then simultaneous read+write on addr 5.
    row(0, 1, 5, 32'h22,       0, 0, 1, 32'hDEADBEEF);
    row(0, 0, 0, 0,            0, 1, 0, 32'hDEADBEEF);
    row(1, 1, 5, 32'h11,       0, 0, 1, 32'hDEADBEEF);
    row(1, 1, 5, 32'h11,       0, 0, 1, 32'hDEADBEEF);
    row(1, 1, 5, 32'h11,       1, 0, 0, 32'h22);
    row(0, 1, 5, 32'h11,       0, 0, 1, 32'h22);
    row(0, 0, 0, 0,            0, 1, 0, 32'h22);
    row(1, 0, 5, 0,            0, 0, 1, 32'h22);
    row(0, 0, 0, 0,            0, 0, 1, 32'h22);
    row(0, 0, 0, 0,            1, 0, 0, 32'h11);
    row(0, 0, 0, 0,            0, 0, 0, 32'h11);
    // Held read of addr 3: one done every 3 cycles.
    row(1, 0, 3, 0,            0, 0, 1, 32'h11);
    row(1, 0, 3, 0,            0, 0, 1, 32'h11);
    row(1, 0, 3, 0,            1, 0, 0, 32'hDEADBEEF);
    for (int i = 0; i < 2; i++) begin
      row(1, 0, 3, 0,          0, 0, 1, 32'hDEADBEEF);
      row(1, 0, 3, 0,          0, 0, 1, 32'hDEADBEEF);
      row(1, 0, 3, 0,          1, 0, 0, 32'hDEADBEEF);
    end
    row(0, 0, 0, 0,            0, 0, 0, 32'hDEADBEEF);
    // Out of range: write 15, write 20, read both back.
    row(0, 1, 15, 32'hAA,      0, 0, 1, 32'hDEADBEEF);
    row(0, 0, 0, 0,            0, 1, 0, 32'hDEADBEEF);
    row(0, 1, 20, 32'h55,      0, 0, 1, 32'hDEADBEEF);
    row(0, 0, 0, 0,            0, 1, 0, 32'hDEADBEEF);
    row(1, 0, 15, 0,           0, 0, 1, 32'hDEADBEEF);
    row(0, 0, 0, 0,            0, 0, 1, 32'hDEADBEEF);
    row(0, 0, 0, 0,            1, 0, 0, 32'hAA);
    row(1, 0, 20, 0,           0, 0, 1, 32'hAA);
    row(0, 0, 0, 0,            0, 0, 1, 32'hAA);
    row(0, 0, 0, 0,            1, 0, 0, 32'h0);
    row(0, 0, 0, 0,            0, 0, 0, 32'h0);
    // Leave out non-zero for the async reset check.
    row(1, 0, 3, 0,            0, 0, 1, 32'h0);
    row(0, 0, 0, 0,            0, 0, 1, 32'h0);
    row(0, 0, 0, 0,            1, 0, 0, 32'hDEADBEEF);

    foreach (tbl[i]) begin
      drive(tbl[i].re, tbl[i].we, tbl[i].a, tbl[i].d);
      tick();
      chk($sformatf("vec%0d", i), tbl[i].x_rd, tbl[i].x_wd, tbl[i].x_busy, tbl[i].x_out);
    end

    // Async reset mid-cycle during READ_BUSY, read_en still high.
    drive(1, 0, 3, 0);
    tick();
    chk("rd_accept", 0, 0, 1, 32'hDEADBEEF);
    #2 reset = 1'b1;
    #1 chk("async_reset", 0, 0, 0, 32'h0);
    tick();
    chk("reset_held", 0, 0, 0, 32'h0);
    drive(0, 0, 0, 0);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("abort_quiet%0d", i), 0, 0, 0, 32'h0);
    end

    // Abort a write to addr 3; array must keep the old value.
    drive(0, 1, 3, 32'h12345678);
    tick();
    chk("wr_accept", 0, 0, 1, 32'h0);
    drive(0, 0, 0, 0);
    #2 reset = 1'b1;
    #1 chk("wr_abort", 0, 0, 0, 32'h0);
    tick();
    reset = 1'b0;
    tick();
    chk("wr_abort_quiet", 0, 0, 0, 32'h0);

    // Addr 3 still holds the original data.
    drive(1, 0, 3, 0);
    tick();
    chk("post_rd_accept", 0, 0, 1, 32'h0);
    drive(0, 0, 0, 0);
    tick();
    chk("post_rd_wait", 0, 0, 1, 32'h0);
    tick();
    chk("post_rd_done", 1, 0, 0, 32'hDEADBEEF);
    tick();
    chk("post_rd_clear", 0, 0, 0, 32'hDEADBEEF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
